// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Imported by the round-robin picker and the arbiter top level.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 3;
    localparam int LAT_CNT_W   = 2;

    // Out-of-range latencies are pulled into the supported window.
    function automatic int clamp_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker with a loader lock override.
// Purely combinational; grant is one-hot, indexed by port_t, zero when idle.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    input  logic       lock,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default first so every path assigns grant and no latch is inferred.
        grant = 2'b00;
        if (lock && req[PORT_LDR]) begin
            grant[PORT_LDR] = 1'b1;
        end else if (req == 2'b11) begin
            grant[(last == PORT_CPU) ? PORT_LDR : PORT_CPU] = 1'b1;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing one memory between the CPU control path and
// the loader/debug port: IDLE -> ACCESS -> (WAIT) -> RESP -> IDLE per transaction.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output logic              busy
);

    localparam int                   LAT      = clamp_lat(MEM_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT - 1);

    arb_state_t           state;
    arb_state_t           next_state;
    port_t                owner;
    port_t                last;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [LAT_CNT_W-1:0] cnt;
    logic [1:0]           grant;
    logic                 capture;

    arb_rr2 u_pick (
        .req   ({ldr_req, cpu_req}),
        .last  (last),
        .lock  (ldr_lock),
        .grant (grant)
    );

    // NOTE: synchronous active-high reset, so it is tested inside the clocked block only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (|grant) next_state = ST_ACCESS;
            ST_ACCESS: next_state = (we_q || LAT_LOAD == '0) ? ST_RESP : ST_WAIT;
            ST_WAIT:   if (cnt == LAT_CNT_W'(1)) next_state = ST_RESP;
            ST_RESP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Read data is sampled on the edge that enters RESP, i.e. MEM_LAT edges
    // after the address first appeared, so rdata is already valid alongside ack.
    assign capture = (next_state == ST_RESP) && (state != ST_RESP) && !we_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= PORT_CPU;
            last      <= PORT_LDR;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            if (state == ST_IDLE && |grant) begin
                owner   <= grant[PORT_LDR] ? PORT_LDR : PORT_CPU;
                we_q    <= grant[PORT_LDR] ? ldr_we    : cpu_we;
                addr_q  <= grant[PORT_LDR] ? ldr_addr  : cpu_addr;
                wdata_q <= grant[PORT_LDR] ? ldr_wdata : cpu_wdata;
            end
            if (state == ST_ACCESS) begin
                cnt <= LAT_LOAD;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                if (owner == PORT_LDR) ldr_rdata <= mem_rdata;
                else                   cpu_rdata <= mem_rdata;
            end
            if (state == ST_RESP) begin
                last <= owner;
            end
        end
    end

    // The address/data latches only move on a grant, so the bus holds in IDLE.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        mem_we    = (state == ST_ACCESS) && we_q;
        cpu_ack   = (state == ST_RESP) && (owner == PORT_CPU);
        ldr_ack   = (state == ST_RESP) && (owner == PORT_LDR);
        busy      = (state != ST_IDLE);
        cpu_stall = ((owner == PORT_LDR) && (state != ST_IDLE)) || ldr_lock;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3.
// A transaction-timeline model is compared every cycle; directed tests pin literal values.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    logic          reset     [2];
    logic          cpu_req   [2];
    logic          cpu_we    [2];
    logic [AW-1:0] cpu_addr  [2];
    logic [DW-1:0] cpu_wdata [2];
    logic          cpu_ack   [2];
    logic [DW-1:0] cpu_rdata [2];
    logic          ldr_req   [2];
    logic          ldr_we    [2];
    logic [AW-1:0] ldr_addr  [2];
    logic [DW-1:0] ldr_wdata [2];
    logic          ldr_lock  [2];
    logic          ldr_ack   [2];
    logic [DW-1:0] ldr_rdata [2];
    logic [AW-1:0] mem_addr  [2];
    logic          mem_we    [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          cpu_stall [2];
    logic          busy      [2];

    function automatic logic [31:0] init_word(input int j);
        return (j == 16) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(j));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] macro [256];
        logic [7:0]  a_d1;
        logic [7:0]  a_d2;

        mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk       (clk),
            .reset     (reset[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_rdata (cpu_rdata[g]),
            .ldr_req   (ldr_req[g]),
            .ldr_we    (ldr_we[g]),
            .ldr_addr  (ldr_addr[g]),
            .ldr_wdata (ldr_wdata[g]),
            .ldr_lock  (ldr_lock[g]),
            .ldr_ack   (ldr_ack[g]),
            .ldr_rdata (ldr_rdata[g]),
            .mem_addr  (mem_addr[g]),
            .mem_we    (mem_we[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .busy      (busy[g])
        );

        // Memory macro: data for an address is readable MEM_LAT edges after it appears.
        initial for (int j = 0; j < 256; j++) macro[j] <= init_word(j);
        always @(posedge clk) begin
            if (mem_we[g]) macro[mem_addr[g][7:0]] <= mem_wdata[g];
            a_d1 <= mem_addr[g][7:0];
            a_d2 <= a_d1;
        end
        assign mem_rdata[g] = (LAT == 1) ? macro[mem_addr[g][7:0]] : macro[a_d2];
    end

    // ---------------- reference model: transaction timeline ----------------
    logic        m_act  [2];
    port_t       m_own  [2];
    port_t       m_last [2];
    logic        m_we   [2];
    int          m_t    [2];
    logic [31:0] m_maddr  [2];
    logic [31:0] m_mwdata [2];
    logic [31:0] m_cpu_rd [2];
    logic [31:0] m_ldr_rd [2];
    logic [31:0] image [2][256];

    initial for (int i = 0; i < 2; i++) for (int j = 0; j < 256; j++) image[i][j] <= init_word(j);

    // Cycle (counted from the ACCESS cycle = 1) in which the owner is acknowledged.
    function automatic int done_t(input int i, input logic we);
        return we ? 2 : 2 + ((i == 0) ? 1 : 3) - 1;
    endfunction

    function automatic port_t pick(input logic c, input logic l, input logic lock, input port_t last);
        if (l && (lock || !c)) return PORT_LDR;
        if (c && !l) return PORT_CPU;
        return (last == PORT_CPU) ? PORT_LDR : PORT_CPU;
    endfunction

    always @(posedge clk) begin
        port_t w;
        for (int i = 0; i < 2; i++) begin
            if (reset[i]) begin
                m_act[i]    <= 1'b0;
                m_t[i]      <= 0;
                m_own[i]    <= PORT_CPU;
                m_last[i]   <= PORT_LDR;
                m_maddr[i]  <= '0;
                m_mwdata[i] <= '0;
                m_cpu_rd[i] <= '0;
                m_ldr_rd[i] <= '0;
            end else if (!m_act[i]) begin
                if (cpu_req[i] || ldr_req[i]) begin
                    w = pick(cpu_req[i], ldr_req[i], ldr_lock[i], m_last[i]);
                    m_act[i]    <= 1'b1;
                    m_t[i]      <= 1;
                    m_own[i]    <= w;
                    m_we[i]     <= (w == PORT_LDR) ? ldr_we[i]    : cpu_we[i];
                    m_maddr[i]  <= (w == PORT_LDR) ? ldr_addr[i]  : cpu_addr[i];
                    m_mwdata[i] <= (w == PORT_LDR) ? ldr_wdata[i] : cpu_wdata[i];
                end
            end else begin
                if (m_t[i] == 1 && m_we[i]) image[i][m_maddr[i][7:0]] <= m_mwdata[i];
                if (!m_we[i] && m_t[i] + 1 == done_t(i, 1'b0)) begin
                    if (m_own[i] == PORT_LDR) m_ldr_rd[i] <= image[i][m_maddr[i][7:0]];
                    else                      m_cpu_rd[i] <= image[i][m_maddr[i][7:0]];
                end
                if (m_t[i] == done_t(i, m_we[i])) begin
                    m_act[i]  <= 1'b0;
                    m_last[i] <= m_own[i];
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: every DUT output against the model, every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                logic ack_now;
                ack_now = m_act[i] && (m_t[i] == done_t(i, m_we[i]));
                check($sformatf("u%0d.busy", i),      64'(busy[i]),      64'(m_act[i]));
                check($sformatf("u%0d.cpu_ack", i),   64'(cpu_ack[i]),   64'(ack_now && m_own[i] == PORT_CPU));
                check($sformatf("u%0d.ldr_ack", i),   64'(ldr_ack[i]),   64'(ack_now && m_own[i] == PORT_LDR));
                check($sformatf("u%0d.mem_we", i),    64'(mem_we[i]),    64'(m_act[i] && m_t[i] == 1 && m_we[i]));
                check($sformatf("u%0d.mem_addr", i),  64'(mem_addr[i]),  64'(m_maddr[i]));
                check($sformatf("u%0d.mem_wdata", i), 64'(mem_wdata[i]), 64'(m_mwdata[i]));
                check($sformatf("u%0d.cpu_stall", i), 64'(cpu_stall[i]),
                      64'((m_act[i] && m_own[i] == PORT_LDR) || ldr_lock[i]));
                check($sformatf("u%0d.cpu_rdata", i), 64'(cpu_rdata[i]), 64'(m_cpu_rd[i]));
                check($sformatf("u%0d.ldr_rdata", i), 64'(ldr_rdata[i]), 64'(m_ldr_rd[i]));
            end
        end
    end

    int cpu_ack_cnt [2] = '{0, 0};
    int ldr_ack_cnt [2] = '{0, 0};
    int mem_we_cnt  [2] = '{0, 0};
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cpu_ack[i]) cpu_ack_cnt[i] <= cpu_ack_cnt[i] + 1;
            if (ldr_ack[i]) ldr_ack_cnt[i] <= ldr_ack_cnt[i] + 1;
            if (mem_we[i])  mem_we_cnt[i]  <= mem_we_cnt[i] + 1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int i, input port_t p, input logic we, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        lat = -1;
        if (p == PORT_CPU) begin
            cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
        end else begin
            ldr_req[i] = 1'b1; ldr_we[i] = we; ldr_addr[i] = a; ldr_wdata[i] = d;
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if ((p == PORT_CPU && cpu_ack[i]) || (p == PORT_LDR && ldr_ack[i])) begin
                lat = n;
                break;
            end
        end
        cpu_req[i] = 1'b0;
        ldr_req[i] = 1'b0;
    endtask

    task automatic do_reset(input int i);
        reset[i] = 1'b1;
        tick();
        tick();
        reset[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0;
            ldr_req[i] = 1'b0; ldr_we[i] = 1'b0; ldr_addr[i] = '0; ldr_wdata[i] = '0;
            ldr_lock[i] = 1'b0;
        end
        tick();
        cmp_en = 1'b1;
        tick();
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_mem_addr", 64'(mem_addr[0]), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata[0]), 64'd0);

        // CPU read of 0x10, MEM_LAT=1
        run_txn(0, PORT_CPU, 1'b0, 32'h10, 32'h0, lat);
        check("t1_cpu_ack_cycle", 64'(lat), 64'd2);
        check("t1_cpu_rdata", 64'(cpu_rdata[0]), 64'h1234_5678);
        tick();
        check("t1_ldr_ack_none", 64'(ldr_ack_cnt[0]), 64'd0);

        // Loader write of 0xDEADBEEF to 0x20
        base = mem_we_cnt[0];
        ldr_req[0] = 1'b1; ldr_we[0] = 1'b1; ldr_addr[0] = 32'h20; ldr_wdata[0] = 32'hDEAD_BEEF;
        tick();
        check("t2_c1_mem_we", 64'(mem_we[0]), 64'd1);
        check("t2_c1_mem_addr", 64'(mem_addr[0]), 64'h20);
        check("t2_c1_stall", 64'(cpu_stall[0]), 64'd1);
        tick();
        check("t2_c2_ldr_ack", 64'(ldr_ack[0]), 64'd1);
        check("t2_c2_stall", 64'(cpu_stall[0]), 64'd1);
        check("t2_c2_mem_we", 64'(mem_we[0]), 64'd0);
        ldr_req[0] = 1'b0; ldr_we[0] = 1'b0;
        tick();
        check("t2_we_pulses", 64'(mem_we_cnt[0] - base), 64'd1);
        check("t2_c3_stall", 64'(cpu_stall[0]), 64'd0);
        run_txn(0, PORT_CPU, 1'b0, 32'h20, 32'h0, lat);
        check("t2_readback", 64'(cpu_rdata[0]), 64'hDEAD_BEEF);
        tick();

        // Continuous contention after reset: CPU, LDR, CPU, LDR, 3 cycles apart
        do_reset(0);
        cpu_req[0] = 1'b1; cpu_addr[0] = 32'h10;
        ldr_req[0] = 1'b1; ldr_addr[0] = 32'h20;
        for (int c = 1; c <= 11; c++) begin
            tick();
            check($sformatf("rr_c%0d_cpu_ack", c), 64'(cpu_ack[0]), 64'(c == 2 || c == 8));
            check($sformatf("rr_c%0d_ldr_ack", c), 64'(ldr_ack[0]), 64'(c == 5 || c == 11));
        end
        tick();
        cpu_req[0] = 1'b0;
        ldr_req[0] = 1'b0;
        tick();

        // Lock: four loader grants, then CPU wins once lock drops
        ldr_lock[0] = 1'b1;
        cpu_req[0] = 1'b1;
        ldr_req[0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c <= 11) begin
                check($sformatf("lk_c%0d_ldr_ack", c), 64'(ldr_ack[0]), 64'(c % 3 == 2));
                check($sformatf("lk_c%0d_cpu_ack", c), 64'(cpu_ack[0]), 64'd0);
                check($sformatf("lk_c%0d_stall", c), 64'(cpu_stall[0]), 64'd1);
                if (c == 11) ldr_lock[0] = 1'b0;
            end else begin
                check($sformatf("lk_c%0d_stall", c), 64'(cpu_stall[0]), 64'd0);
                check($sformatf("lk_c%0d_cpu_ack", c), 64'(cpu_ack[0]), 64'(c == 14));
            end
        end
        cpu_req[0] = 1'b0;
        ldr_req[0] = 1'b0;
        tick();

        // MEM_LAT=3 read: address stable through ACCESS and WAIT, ack at cycle 4
        cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h10;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) cpu_addr[1] = 32'h44;
            if (c <= 3) check($sformatf("l3_c%0d_mem_addr", c), 64'(mem_addr[1]), 64'h10);
            check($sformatf("l3_c%0d_cpu_ack", c), 64'(cpu_ack[1]), 64'(c == 4));
        end
        check("l3_cpu_rdata", 64'(cpu_rdata[1]), 64'h1234_5678);
        cpu_req[1] = 1'b0;
        tick();

        // Reset during WAIT: abort, no ack, then a fresh loader read completes
        cpu_req[1] = 1'b1; cpu_addr[1] = 32'h30;
        tick();
        tick();
        reset[1] = 1'b1;
        base = cpu_ack_cnt[1];
        tick();
        reset[1] = 1'b0;
        cpu_req[1] = 1'b0;
        check("rw_busy", 64'(busy[1]), 64'd0);
        check("rw_mem_we", 64'(mem_we[1]), 64'd0);
        check("rw_mem_addr", 64'(mem_addr[1]), 64'd0);
        check("rw_cpu_rdata", 64'(cpu_rdata[1]), 64'd0);
        for (int c = 0; c < 5; c++) tick();
        check("rw_no_ack", 64'(cpu_ack_cnt[1] - base), 64'd0);
        run_txn(1, PORT_LDR, 1'b0, 32'h10, 32'h0, lat);
        check("rw_fresh_ack_cycle", 64'(lat), 64'd4);
        check("rw_fresh_rdata", 64'(ldr_rdata[1]), 64'h1234_5678);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single unified instruction/data memory of the multicycle CPU. Shares the memory between the CPU control path (fetch, lw, sw) and a program loader/debug port. Sequences each granted transaction through a fixed ACCESS/WAIT/RESP handshake and holds the loser off with an explicit ack-based stall. Sits between the CPU datapath memory mux and the memory macro.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..3
- `clk` in 1: the single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU request; held until `cpu_ack`.
- `cpu_we` in 1: CPU write request.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `cpu_rdata` out DATA_W: registered read data for the CPU; valid with `cpu_ack`.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata` in 1/1/ADDR_W/DATA_W: loader request, same meaning as the CPU fields.
- `ldr_lock` in 1: loader requests priority over consecutive transactions.
- `ldr_ack`, `ldr_rdata` out 1/DATA_W: loader completion pulse and read data.
- `mem_addr` out ADDR_W, `mem_we` out 1, `mem_wdata` out DATA_W: memory port.
- `mem_rdata` in DATA_W: memory read data, valid `MEM_LAT` cycles after the address is presented.
- `cpu_stall` out 1: high while the loader owns the memory or `ldr_lock` is high.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- **IDLE**
  - Sample the requests.
  - If `ldr_lock` && `ldr_req`, grant the loader.
  - Otherwise, if only one request is high, grant it.
  - If both are high, grant the port that did not win last (round-robin).
  - On a grant, latch owner/we/addr/wdata and go to ACCESS.
- **ACCESS**
  - Drive `mem_addr`/`mem_wdata` from the latched fields.
  - `mem_we` = latched we, high for exactly this one cycle.
  - Write: go to RESP.
  - Read: load the latency counter with `MEM_LAT`-1. Go to WAIT if it is nonzero, else RESP.
- **WAIT**: hold `mem_addr`; decrement the counter; go to RESP at 0.
- **RESP**
  - Pulse the owner's ack.
  - On a read, register `mem_rdata` into the owner's rdata.
  - Update the last-winner register to the owner; return to IDLE.
- The non-owner's rdata holds its previous value.
- Requesters must hold req and its fields stable until ack. Changes after the grant are ignored.
- Req dropped mid-transaction: the transaction still completes and ack still pulses.
- Req still high in the IDLE cycle after ack is treated as a new request.
- `mem_addr`/`mem_wdata` hold their last values in IDLE; `mem_we` is 0 outside ACCESS.
- `cpu_stall` = (owner==LDR && state!=IDLE) || `ldr_lock`. It is combinational from registered state and the `ldr_lock` input.
- Reset mid-transaction: the transaction is aborted and no ack is issued. `mem_we` is 0 in the following cycle.

## Timing
- Reset values: state IDLE, `cpu_ack`=`ldr_ack`=0, both rdata=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, last-winner=LDR. Because last-winner resets to LDR, the first contention goes to the CPU.
- Write latency: req sampled in IDLE at cycle 0, ACCESS at cycle 1, ack at cycle 2.
- Read latency: ack at cycle 2+(`MEM_LAT`-1). rdata is valid in the ack cycle.
- Throughput: one transaction per (3 + `MEM_LAT`-1) cycles for reads and 3 cycles for writes. The IDLE dead cycle is mandatory.
- Simultaneous ack to both ports is impossible; at most one ack per cycle.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3)
  - port IDs (CPU=0, LDR=1)
  - `MEM_LAT` legal-range constants
- One sub-module, `arb_rr2`: a two-requester round-robin picker with lock override.
  - Inputs: `req[1:0]`, `last`, `lock`.
  - Output: `grant`.
  - Purely combinational.
- The top level holds the FSM, request latches, latency counter and rdata registers.

## Test plan
- Reset, then CPU read of addr 0x10 with memory word 0x12345678 and `MEM_LAT`=1 -> `cpu_ack` at cycle 2, `cpu_rdata`=0x12345678, `ldr_ack` never pulses.
- Loader write of 0xDEADBEEF to addr 0x20 -> `mem_we` high for exactly one cycle with `mem_addr`=0x20; `ldr_ack` at cycle 2; `cpu_stall` high in cycles 1-2.
- Both ports request reads continuously after reset -> grants alternate CPU, LDR, CPU, LDR, with acks 3 cycles apart.
- `ldr_lock` high and both ports requesting for 4 transactions -> all 4 go to the loader and `cpu_stall` stays high. Lock drops -> the next grant goes to the CPU.
- `MEM_LAT`=3 read -> WAIT lasts 2 cycles, `mem_addr` stays stable throughout, ack at cycle 4.
- `reset` asserted during WAIT -> the next cycle is IDLE, no ack, all outputs at reset values; a fresh request afterward completes normally.
